// File: rtl/bridge_pkg.sv
// Shared types for the stream-to-SDRAM bridge: FSM state encoding and the
// posted-write FIFO entry layout at the default bus widths.
package bridge_pkg;

  localparam int unsigned PKG_ADDR_W     = 32;
  localparam int unsigned PKG_DATA_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    RD_ISSUE,
    RD_RESP
  } bridge_state_t;

  typedef struct packed {
    logic [PKG_ADDR_W-1:0]       addr;
    logic [8*PKG_DATA_BYTES-1:0] data;
    logic [PKG_DATA_BYTES-1:0]   be;
  } wr_entry_t;

endpackage

// File: rtl/stream_sdram_bridge_if.sv
// Avalon-MM bus bundle; one instance per side of the bridge.
interface stream_sdram_bridge_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_BYTES = 4
);

  logic [ADDR_W-1:0]       address;
  logic                    write;
  logic                    read;
  logic [8*DATA_BYTES-1:0] writedata;
  logic [DATA_BYTES-1:0]   byteenable;
  logic [8*DATA_BYTES-1:0] readdata;
  logic                    waitrequest;

  modport master (
    output address, write, read, writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, write, read, writedata, byteenable,
    output readdata, waitrequest
  );

endinterface

// File: rtl/bridge_fifo.sv
// Synchronous FIFO for posted writes; pointers carry an extra wrap bit so
// full/empty fall out of the pointer difference.
module bridge_fifo
  import bridge_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter type         entry_t = wr_entry_t,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty,
  output logic [AW:0] level
);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH];
  logic        push_ok;
  logic        pop_ok;

  // Full is judged before any same-cycle pop, so a full FIFO never takes a push.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign level = wr_ptr - rd_ptr;
  assign full  = level[AW];
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/stream_sdram_bridge.sv
// Host-side Avalon-MM agent that posts writes into a FIFO and replays them to
// SDRAM at BASE_ADDR; reads wait until all posted writes have drained.
module stream_sdram_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_BYTES = 4,
  parameter int unsigned       FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  stream_sdram_bridge_if.slave        s_bus,
  stream_sdram_bridge_if.master       m_bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy
);

  typedef struct packed {
    logic [ADDR_W-1:0]       addr;
    logic [8*DATA_BYTES-1:0] data;
    logic [DATA_BYTES-1:0]   be;
  } entry_t;

  bridge_state_t           state;
  logic [ADDR_W-1:0]       host_addr;
  logic [ADDR_W-1:0]       rd_addr;
  logic [8*DATA_BYTES-1:0] rdata_q;
  entry_t                  push_data;
  entry_t                  head;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    wr_phase;

  assign host_addr = s_bus.address + BASE_ADDR;
  assign push_data = '{addr: host_addr, data: s_bus.writedata, be: s_bus.byteenable};
  assign push      = (state == IDLE) && s_bus.write && !s_bus.read;

  bridge_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Replay only outside the read-issue window so m_read and m_write never overlap.
  assign wr_phase           = (state == IDLE) || (state == DRAIN);
  assign m_bus.write        = wr_phase && !fifo_empty;
  assign m_bus.read         = (state == RD_ISSUE);
  assign m_bus.address      = (state == RD_ISSUE) ? rd_addr : head.addr;
  assign m_bus.writedata    = head.data;
  assign m_bus.byteenable   = head.be;
  assign pop                = m_bus.write && !m_bus.waitrequest;

  assign s_bus.readdata     = rdata_q;
  assign busy               = !fifo_empty || (state != IDLE);

  always_comb begin
    s_bus.waitrequest = 1'b1;
    if (!sys_rst) begin
      case (state)
        IDLE:    s_bus.waitrequest = s_bus.read ? 1'b1 : fifo_full;
        RD_RESP: s_bus.waitrequest = 1'b0;
        default: s_bus.waitrequest = 1'b1;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= IDLE;
      rd_addr <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_bus.read) begin
            rd_addr <= host_addr;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) state <= RD_ISSUE;
        end
        RD_ISSUE: begin
          if (!m_bus.waitrequest) begin
            rdata_q <= m_bus.readdata;
            state   <= RD_RESP;
          end
        end
        RD_RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
